// File: rtl/uart_rx_typed_dechunker_pkg.sv
// Shared constants and state encoding for the typed chunk framing
// (used by both the RX dechunker and the TX chunker).
package uart_rx_typed_dechunker_pkg;

  localparam logic [7:0] ESCAPE_BYTE   = 8'h00;
  localparam logic [7:0] RESERVED_TYPE = 8'h00;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    HUNT_ESC = 2'd1,
    DATA     = 2'd2,
    DATA_ESC = 2'd3
  } chunk_state_e;

  function automatic logic is_escape(input logic [7:0] b);
    return b == ESCAPE_BYTE;
  endfunction

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Idle-gap timer: counts enabled cycles since the last clear and pulses
// expired for one cycle when IDLE_TICKS cycles have passed.
module uart_rx_idle_timer #(
  parameter int IDLE_TICKS = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        hit;

  assign hit       = (cnt_q == 32'(IDLE_TICKS - 1));
  // A clear in the same cycle suppresses the pulse, so a received byte wins.
  assign expired_o = enable_i && !clear_i && hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_typed_dechunker.sv
// Removes null-byte escaping from the UART RX byte stream and emits each
// rebuilt typed chunk as a parallel buffer with a one-cycle chunk_valid.
module uart_rx_typed_dechunker
  import uart_rx_typed_dechunker_pkg::*;
#(
  parameter int BUFFER_BYTE_SIZE  = 5,
  parameter int BUFFER_INDEX_SIZE = 32,
  parameter int IDLE_TICKS        = 100000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  // rx_ready is a one-cycle strobe qualifying rx_data; there is no
  // backpressure in either direction, chunk_valid must be captured when high.
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  output logic                          chunk_valid,
  output logic [7:0]                    chunk_type,
  output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
  output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
  output logic                          chunk_active,
  output logic                          framing_error,
  output logic [1:0]                    dbg_state_o
);

  localparam logic [BUFFER_INDEX_SIZE-1:0] FULL_CNT = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);

  chunk_state_e                  state_q, state_d;
  logic [7:0]                    type_q, type_d;
  logic [BUFFER_BYTE_SIZE*8-1:0] buf_q, buf_d;
  logic [BUFFER_INDEX_SIZE-1:0]  cnt_q, cnt_d;

  logic                          valid_q, type_out_q, ferr_q;
  logic [7:0]                    out_type_q;
  logic [BUFFER_INDEX_SIZE-1:0]  out_size_q;
  logic [BUFFER_BYTE_SIZE*8-1:0] out_bytes_q;

  logic                          emit_d, ferr_d, do_store, expired;
  logic [BUFFER_INDEX_SIZE-1:0]  emit_size;
  logic [BUFFER_BYTE_SIZE*8-1:0] emit_bytes;

  uart_rx_idle_timer #(
    .IDLE_TICKS(IDLE_TICKS)
  ) u_idle_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .clear_i  (rx_ready),
    .enable_i (chunk_active),
    .expired_o(expired)
  );

  assign chunk_active = (state_q == DATA) || (state_q == DATA_ESC);

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    emit_d     = 1'b0;
    ferr_d     = 1'b0;
    do_store   = 1'b0;
    emit_size  = cnt_q;
    emit_bytes = buf_q;
    if (rx_ready) begin
      case (state_q)
        HUNT: begin
          if (is_escape(rx_data)) state_d = HUNT_ESC;
          else                    ferr_d  = 1'b1;
        end
        HUNT_ESC: begin
          if (!is_escape(rx_data)) begin
            type_d  = rx_data;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = DATA;
          end else begin
            ferr_d  = 1'b1;
            state_d = HUNT;
          end
        end
        DATA: begin
          if (is_escape(rx_data)) state_d  = DATA_ESC;
          else                    do_store = 1'b1;
        end
        DATA_ESC: begin
          if (is_escape(rx_data)) begin
            do_store = 1'b1;
            state_d  = DATA;
          end else begin
            // Close the current chunk with its old contents, open the next.
            emit_d  = 1'b1;
            type_d  = rx_data;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        default: state_d = HUNT;
      endcase
      if (do_store) begin
        for (int i = 0; i < BUFFER_BYTE_SIZE; i++) begin
          if (cnt_q == BUFFER_INDEX_SIZE'(i)) buf_d[8*i +: 8] = rx_data;
        end
        cnt_d = cnt_q + BUFFER_INDEX_SIZE'(1);
        if (cnt_d == FULL_CNT) begin
          emit_d     = 1'b1;
          emit_size  = cnt_d;
          emit_bytes = buf_d;
          state_d    = HUNT;
        end
      end
    end else if (expired) begin
      emit_d  = 1'b1;
      state_d = HUNT;
      if (state_q == DATA_ESC) ferr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HUNT;
      type_q      <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      out_type_q  <= '0;
      out_size_q  <= '0;
      out_bytes_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= emit_d;
      ferr_q  <= ferr_d;
      if (emit_d) begin
        out_type_q  <= type_q;
        out_size_q  <= emit_size;
        out_bytes_q <= emit_bytes;
      end
    end
  end

  assign type_out_q      = 1'b0;
  assign chunk_valid     = valid_q;
  assign chunk_type      = out_type_q;
  assign chunk_byte_size = out_size_q;
  assign chunk_bytes     = out_bytes_q;
  assign framing_error   = ferr_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/uart_rx_typed_dechunker.md
Name: uart_rx_typed_dechunker

Overview:
Receive-side counterpart of the typed chunk sender. It consumes the byte stream from the UART RX core (rx_ready/rx_data) and removes the null-byte escaping. It rebuilds typed chunks and presents each completed chunk as a parallel buffer with its type, a byte count and a one-cycle valid pulse. It sits between uart_rx and application logic, for example LED or command decoding in main.

Parameters:
BUFFER_BYTE_SIZE, 5, maximum payload bytes per chunk; also the width of the chunk_bytes output in bytes.
BUFFER_INDEX_SIZE, 32, width of chunk_byte_size and of the internal byte counter.
IDLE_TICKS, 100000, clock cycles with no received byte that close an open chunk (1 ms at 100 MHz).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
rx_ready  input  1  one-cycle strobe from uart_rx: rx_data is valid this cycle.
rx_data  input  8  received byte.
chunk_valid  output  1  one-cycle pulse: chunk_type, chunk_byte_size and chunk_bytes hold a new chunk.
chunk_type  output  8  type byte of the emitted chunk; never 0.
chunk_byte_size  output  BUFFER_INDEX_SIZE  number of payload bytes, 0 to BUFFER_BYTE_SIZE.
chunk_bytes  output  BUFFER_BYTE_SIZE*8  payload; byte i at [8i+7:8i]; unused bytes read 0.
chunk_active  output  1  high while a chunk is open (states DATA and DATA_ESC).
framing_error  output  1  one-cycle pulse on any protocol violation.

Behaviour:
- Wire format: [00][T] opens a chunk of type T, where T is not 0. Inside a chunk, [00][00] is a literal 0x00 and any nonzero byte is a literal byte. Type 0 is reserved because [00][00] is always an escaped null.
- Reset (RST_N low, asynchronous): state=HUNT; all outputs 0; internal buffer, counter and idle timer 0.
- Bytes are processed only in cycles where rx_ready=1. rx_data is ignored otherwise.
- State HUNT:
  - byte 00 -> HUNT_ESC.
  - nonzero byte -> discard, framing_error pulse, stay in HUNT.
- State HUNT_ESC:
  - nonzero T -> latch type=T, clear buffer, count=0 -> DATA.
  - byte 00 -> discard, framing_error pulse -> HUNT.
- State DATA:
  - byte 00 -> DATA_ESC.
  - nonzero byte -> store at index count, count+1.
- State DATA_ESC:
  - byte 00 -> store 0x00 at index count, count+1 -> DATA.
  - nonzero T -> emit the current chunk, then open a new chunk with type T (cleared buffer, count=0) -> DATA. Both happen in the same cycle.
- Buffer full: when a store makes count equal BUFFER_BYTE_SIZE, emit with size BUFFER_BYTE_SIZE -> HUNT. Any further payload before a new header raises framing_error.
- Idle timer:
  - Counts only in DATA and DATA_ESC; resets to 0 on every rx_ready and on entering DATA.
  - On reaching IDLE_TICKS: emit the chunk -> HUNT.
  - If the timeout occurs in DATA_ESC, the dangling escape is dropped and framing_error is also pulsed.
- Emit: in the cycle after the triggering rx_ready (or timeout) cycle, the output registers are loaded and chunk_valid=1 for exactly one cycle. Outputs hold their values until the next emit.
- Zero-length chunks (header then a header or timeout with count=0) are emitted with chunk_byte_size=0.
- Simultaneous rx_ready and timeout in the same cycle: the byte wins and the timer is cleared.
- A back-to-back emit is possible one byte-time apart. No backpressure: the consumer must capture on chunk_valid.
- Reset mid-chunk: the partial chunk is discarded and no chunk_valid is produced.
- Width rules: the counter never exceeds BUFFER_BYTE_SIZE, and the timer is 32 bits wide.

Decomposition:
- Shared package / include file:
  - ESCAPE_BYTE = 8'h00.
  - State encoding HUNT, HUNT_ESC, DATA, DATA_ESC (2 bits).
  - Reserved-type constant 0.
  - The same file is to be reused by uart_tx_typed_chunker.
- Sub-module uart_rx_idle_timer: IDLE_TICKS parameter; inputs clear and enable; output one-cycle expired pulse. The FSM, buffer and output registers stay in the top module.

Test Plan:
- Bytes 00 01 42 43 44 00 00 44, then idle for IDLE_TICKS -> one chunk_valid; type 01, size 5, chunk_bytes=40'h44_00_44_43_42; framing_error never asserted.
- Bytes 00 02 AA 00 03 BB, then idle -> first emit: type 02, size 1, bytes 40'h00_00_00_00_AA; second emit: type 03, size 1, bytes 40'h00_00_00_00_BB.
- Bytes 00 05 01 02 03 04 05 06 -> emit type 05, size 5, 40'h05_04_03_02_01 immediately after byte 05; byte 06 -> framing_error pulse; chunk_active=0.
- Byte 55 in HUNT, then 00 00 -> two framing_error pulses, no chunk_valid, state HUNT.
- Bytes 00 07 11 00, then idle -> emit type 07, size 1, bytes 40'h11 plus a framing_error pulse; separately, RST_N low after 00 07 11 -> no emit and all outputs 0.
